// File: rtl/riscv_pipe_pkg.sv
// Shared types for the Memory->Writeback elastic pipeline register:
// the packed M/W payload and the buffer occupancy states.
package riscv_pipe_pkg;

    localparam int MW_DATA_WIDTH     = 32;
    localparam int MW_REG_ADDR_WIDTH = 5;

    typedef struct packed {
        logic                         reg_write;
        logic [1:0]                   result_src;
        logic [MW_DATA_WIDTH-1:0]     alu_result;
        logic [MW_DATA_WIDTH-1:0]     read_data;
        logic [MW_DATA_WIDTH-1:0]     pc_plus4;
        logic [MW_REG_ADDR_WIDTH-1:0] rd;
    } mw_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        SKID  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready buffer: main register plus optional skid register.
// PIPEREG_MW_SKID_EN adds the skid entry and makes in_ready purely state-derived.
module pipe_skid_buf
    import riscv_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    buf_state_t       state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
`ifdef PIPEREG_MW_SKID_EN
    logic [WIDTH-1:0] skid_q,  skid_d;
`endif

    logic in_fire;
    logic out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

`ifdef PIPEREG_MW_SKID_EN
    assign in_ready = rst_n && (state_q != SKID);
`else
    // Without a skid entry we may only accept when the head is leaving.
    assign in_ready = rst_n && (out_ready || !out_valid);
`endif

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPEREG_MW_SKID_EN
        skid_d  = skid_q;
`endif
        if (clr) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = MAIN;
                        main_d  = in_data;
                    end
                end
                MAIN: begin
`ifdef PIPEREG_MW_SKID_EN
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = SKID;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
`else
                    if (in_fire) begin
                        main_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
`endif
                end
`ifdef PIPEREG_MW_SKID_EN
                SKID: begin
                    if (out_fire) begin
                        state_d = MAIN;
                        main_d  = skid_q;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
`ifdef PIPEREG_MW_SKID_EN
            skid_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef PIPEREG_MW_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

endmodule

// File: rtl/pipereg_mw_elastic.sv
// Memory->Writeback elastic pipeline register with valid/ready handshake.
// Define PIPEREG_MW_SKID_EN to build with the skid register (registered ready_m).
module pipereg_mw_elastic
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = MW_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = MW_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      valid_m,
    output logic                      ready_m,
    input  logic                      RegWriteM,
    input  logic [1:0]                ResultSrcM,
    input  logic [DATA_WIDTH-1:0]     ALUResultM,
    input  logic [DATA_WIDTH-1:0]     ReadDataM,
    input  logic [DATA_WIDTH-1:0]     PCPlus4M,
    input  logic [REG_ADDR_WIDTH-1:0] RDM,
    output logic                      valid_w,
    input  logic                      ready_w,
    output logic                      RegWriteW,
    output logic [1:0]                ResultSrcW,
    output logic [DATA_WIDTH-1:0]     ALUResultW,
    output logic [DATA_WIDTH-1:0]     ReadDataW,
    output logic [DATA_WIDTH-1:0]     PCPlus4W,
    output logic [REG_ADDR_WIDTH-1:0] RDW
);

    // The payload struct is fixed-width, so the parameters must agree with it.
    if (DATA_WIDTH != MW_DATA_WIDTH || REG_ADDR_WIDTH != MW_REG_ADDR_WIDTH) begin : g_width_check
        $error("pipereg_mw_elastic: widths must match riscv_pipe_pkg payload");
    end

    mw_payload_t m_pl;
    mw_payload_t w_pl;

    assign m_pl.reg_write  = RegWriteM;
    assign m_pl.result_src = ResultSrcM;
    assign m_pl.alu_result = ALUResultM;
    assign m_pl.read_data  = ReadDataM;
    assign m_pl.pc_plus4   = PCPlus4M;
    assign m_pl.rd         = RDM;

    pipe_skid_buf #(
        .WIDTH($bits(mw_payload_t))
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (valid_m),
        .in_ready  (ready_m),
        .in_data   (m_pl),
        .out_valid (valid_w),
        .out_ready (ready_w),
        .out_data  (w_pl)
    );

    // A bubble must never write the register file, even though data is held.
    assign RegWriteW  = valid_w && w_pl.reg_write;
    assign ResultSrcW = w_pl.result_src;
    assign ALUResultW = w_pl.alu_result;
    assign ReadDataW  = w_pl.read_data;
    assign PCPlus4W   = w_pl.pc_plus4;
    assign RDW        = w_pl.rd;

endmodule

// File: tb/tb_pipereg_mw_elastic.sv
// Self-checking bench for pipereg_mw_elastic against a queue-based occupancy model;
// works for both builds (PIPEREG_MW_SKID_EN defined or not).
module tb_pipereg_mw_elastic;
    import riscv_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, clr, valid_m, ready_w;
    logic        ready_m, valid_w;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RDW;
    mw_payload_t in_pl;
    mw_payload_t out_pl;

    always #5 clk = ~clk;

    assign out_pl = {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RDW};

    pipereg_mw_elastic dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .valid_m    (valid_m),
        .ready_m    (ready_m),
        .RegWriteM  (in_pl.reg_write),
        .ResultSrcM (in_pl.result_src),
        .ALUResultM (in_pl.alu_result),
        .ReadDataM  (in_pl.read_data),
        .PCPlus4M   (in_pl.pc_plus4),
        .RDM        (in_pl.rd),
        .valid_w    (valid_w),
        .ready_w    (ready_w),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .RDW        (RDW)
    );

    // Reference model: FIFO of accepted payloads, head is what Writeback sees.
    mw_payload_t mq[$];
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic model_ready();
        if (!rst_n) return 1'b0;
`ifdef PIPEREG_MW_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || ready_w;
`endif
    endfunction

    function automatic mw_payload_t rand_pl(input logic [4:0] rd);
        mw_payload_t p;
        p.reg_write  = 1'($urandom_range(1, 0));
        p.result_src = 2'($urandom_range(3, 0));
        p.alu_result = $urandom;
        p.read_data  = $urandom;
        p.pc_plus4   = $urandom;
        p.rd         = rd;
        return p;
    endfunction

    task automatic tick();
        logic fin, fout;
        fin  = valid_m && model_ready();
        fout = (mq.size() > 0) && ready_w;
        @(posedge clk);
        if (!rst_n || clr) begin
            mq.delete();
        end else begin
            if (fout) void'(mq.pop_front());
            if (fin) mq.push_back(in_pl);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; ready_w = 1'b1; valid_m = 1'b1;
        in_pl = rand_pl(5'd3);
        in_pl.alu_result = 32'hDEADBEEF;
        in_pl.reg_write = 1'b1;
        repeat (2) tick();
        n_cmp++; if (valid_w !== 1'b0) begin n_fail++; $display("FAIL reset_valid_w got=%b exp=0", valid_w); end
        n_cmp++; if (ALUResultW !== 32'h0) begin n_fail++; $display("FAIL reset_alu got=%h exp=0", ALUResultW); end
        n_cmp++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got=%b exp=0", RegWriteW); end
        n_cmp++; if (RDW !== 5'd0) begin n_fail++; $display("FAIL reset_rdw got=%0d exp=0", RDW); end
        n_cmp++; if (ready_m !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low got=%b exp=0", ready_m); end
        rst_n = 1'b1; valid_m = 1'b0;
        #1;
        n_cmp++; if (ready_m !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got=%b exp=1", ready_m); end
        $display("test_reset done");
    endtask

    task automatic test_streaming();
        ready_w = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            valid_m = 1'b1;
            in_pl = rand_pl(5'(i));
            #1;
            n_cmp++; if (ready_m !== 1'b1) begin n_fail++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, ready_m); end
            tick();
            n_cmp++; if (valid_w !== 1'b1 || RDW !== 5'(i)) begin
                n_fail++; $display("FAIL stream_rdw i=%0d got v=%b rd=%0d exp v=1 rd=%0d", i, valid_w, RDW, i);
            end
            n_cmp++; if (out_pl !== mq[0]) begin n_fail++; $display("FAIL stream_payload i=%0d got=%h exp=%h", i, out_pl, mq[0]); end
            $display("xfer rd=%0d alu=%h", RDW, ALUResultW);
        end
        valid_m = 1'b0;
        tick();
        n_cmp++; if (valid_w !== 1'b0) begin n_fail++; $display("FAIL stream_drain got=%b exp=0", valid_w); end
    endtask

    task automatic test_backpressure();
        mw_payload_t pend[$];
        logic [4:0]  got[$];
        pend.push_back(rand_pl(5'd3));
        pend.push_back(rand_pl(5'd4));
        for (int cyc = 0; cyc < 16; cyc++) begin
            logic acc;
            valid_m = (pend.size() > 0);
            if (pend.size() > 0) in_pl = pend[0];
            ready_w = (cyc >= 4);
            #1;
            n_cmp++; if (ready_m !== model_ready()) begin n_fail++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, ready_m, model_ready()); end
`ifdef PIPEREG_MW_SKID_EN
            if (cyc == 2) begin
                n_cmp++; if (ready_m !== 1'b0) begin n_fail++; $display("FAIL bp_skid_full got=%b exp=0", ready_m); end
            end
`endif
            acc = valid_m && model_ready();
            if (valid_w && ready_w) got.push_back(RDW);
            tick();
            if (acc) void'(pend.pop_front());
            n_cmp++; if (valid_w !== (mq.size() > 0) || (mq.size() > 0 && out_pl !== mq[0])) begin
                n_fail++; $display("FAIL bp_out cyc=%0d got v=%b pl=%h exp v=%b", cyc, valid_w, out_pl, mq.size() > 0);
            end
        end
        n_cmp++; if (got.size() != 2 || got[0] !== 5'd3 || got[1] !== 5'd4) begin
            n_fail++; $display("FAIL bp_order got n=%0d exp 2 entries rd 3,4", got.size());
        end
        valid_m = 1'b0;
    endtask

    task automatic test_flush();
        ready_w = 1'b0;
        valid_m = 1'b1; in_pl = rand_pl(5'd5); tick();
        valid_m = 1'b1; in_pl = rand_pl(5'd6); tick();
        n_cmp++; if (valid_w !== 1'b1 || RDW !== 5'd5) begin n_fail++; $display("FAIL flush_pre got v=%b rd=%0d exp v=1 rd=5", valid_w, RDW); end
        clr = 1'b1; valid_m = 1'b1; in_pl = rand_pl(5'd7); in_pl.reg_write = 1'b1;
        tick();
        clr = 1'b0; valid_m = 1'b0;
        n_cmp++; if (valid_w !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", valid_w); end
        n_cmp++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL flush_regwrite got=%b exp=0", RegWriteW); end
        ready_w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (valid_w !== 1'b0) begin n_fail++; $display("FAIL flush_leak i=%0d got v=%b rd=%0d exp v=0", i, valid_w, RDW); end
        end
    endtask

    task automatic test_bubble();
        ready_w = 1'b1; valid_m = 1'b1;
        in_pl = rand_pl(5'd9); in_pl.reg_write = 1'b1;
        tick();
        valid_m = 1'b0;
        n_cmp++; if (valid_w !== 1'b1 || RegWriteW !== 1'b1) begin n_fail++; $display("FAIL bubble_live got v=%b rw=%b exp 1 1", valid_w, RegWriteW); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (valid_w !== 1'b0 || RegWriteW !== 1'b0) begin n_fail++; $display("FAIL bubble_gate i=%0d got v=%b rw=%b exp 0 0", i, valid_w, RegWriteW); end
        end
    endtask

    task automatic test_ready_toggle();
        logic [2:0] pat;
        pat = 3'b101;
        ready_w = 1'b0; valid_m = 1'b1; in_pl = rand_pl(5'd10);
        tick();
        valid_m = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            ready_w = pat[k];
            #1;
            n_cmp++; if (ready_m !== model_ready()) begin n_fail++; $display("FAIL toggle_ready rw=%b got=%b exp=%b", ready_w, ready_m, model_ready()); end
        end
        n_cmp++; if (RDW !== 5'd10 || valid_w !== 1'b1) begin n_fail++; $display("FAIL toggle_head got v=%b rd=%0d exp v=1 rd=10", valid_w, RDW); end
        tick();
        n_cmp++; if (valid_w !== 1'b0) begin n_fail++; $display("FAIL toggle_drain got=%b exp=0", valid_w); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            valid_m = ($urandom_range(3, 0) != 0);
            in_pl   = rand_pl(5'($urandom_range(31, 0)));
            ready_w = ($urandom_range(2, 0) != 0);
            clr     = ($urandom_range(24, 0) == 0);
            #1;
            n_cmp++; if (ready_m !== model_ready()) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, ready_m, model_ready()); end
            tick();
            n_cmp++;
            if (mq.size() > 0) begin
                if (valid_w !== 1'b1 || out_pl !== mq[0]) begin
                    n_fail++; $display("FAIL rand_out cyc=%0d got v=%b pl=%h exp v=1 pl=%h", cyc, valid_w, out_pl, mq[0]);
                end
            end else if (valid_w !== 1'b0 || RegWriteW !== 1'b0) begin
                n_fail++; $display("FAIL rand_empty cyc=%0d got v=%b rw=%b exp 0 0", cyc, valid_w, RegWriteW);
            end
        end
        clr = 1'b0; valid_m = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble();
        test_ready_toggle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
